// File: rtl/prog_loader_if.sv
// ============================================================================
// Module   : prog_loader_if
// Purpose  : Byte-stream handshake and instruction-memory write bus for the
//            LEGv8 boot loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prog_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;

    // master: stream source / memory observer; slave: the loader itself
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module   : prog_loader
// Purpose  : Boot stage that streams a checksummed program image into
//            instruction memory and releases the core at the header start PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  wire logic             CLK,
    input  wire logic             resetl,
    input  wire logic             reload,
    prog_loader_if.slave          bus,
    output logic [63:0]           startpc,
    output logic                  core_run,
    output logic                  load_done,
    output logic                  load_err,
    output logic [CNT_W-1:0]      words_loaded
);

    localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_HDR_PC  = 3'd0,
        S_HDR_CNT = 3'd1,
        S_DATA    = 3'd2,
        S_CSUM    = 3'd3,
        S_RUN     = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [2:0]         r_byte_idx;
    logic [7:0]         r_cnt_lo;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_word_idx;
    logic [7:0]         r_csum;
    logic [31:0]        r_word_buf;
    logic               r_wr_pend;

    logic               w_ready;
    logic               w_accept;
    logic               w_last_byte;
    logic [15:0]        w_hdr_count;
    logic [CNT_W-1:0]   w_prev_idx;
    logic [63:0]        w_wr_addr;

    // reload wins over any byte offered in the same cycle
    assign w_ready = !reload && ((r_state == S_HDR_PC) || (r_state == S_HDR_CNT) ||
                                 (r_state == S_DATA)   || (r_state == S_CSUM));
    assign w_accept     = bus.in_valid && w_ready;
    assign bus.in_ready = w_ready;
    assign w_hdr_count  = {bus.in_data, r_cnt_lo};

    // r_word_idx has already advanced past the word being written out
    assign w_prev_idx = r_word_idx - CNT_W'(1);
    assign w_wr_addr  = startpc + {{(62-CNT_W){1'b0}}, w_prev_idx, 2'b00};

    always_ff @(posedge CLK) begin
        if (resetl) begin
            r_state <= S_HDR_PC;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_last_byte  = 1'b0;
        case (r_state)
            S_HDR_PC: begin
                w_last_byte = (r_byte_idx == 3'd7);
                if (w_accept && w_last_byte) w_next_state = S_HDR_CNT;
            end
            S_HDR_CNT: begin
                w_last_byte = (r_byte_idx == 3'd1);
                if (w_accept && w_last_byte) begin
                    if ({16'd0, w_hdr_count} > c_max_words) w_next_state = S_ERR;
                    else if (w_hdr_count == 16'd0)          w_next_state = S_CSUM;
                    else                                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                w_last_byte = (r_byte_idx == 3'd3);
                if (w_accept && w_last_byte && (r_word_idx == r_count - CNT_W'(1)))
                    w_next_state = S_CSUM;
            end
            S_CSUM: begin
                w_last_byte = 1'b1;
                if (w_accept)
                    w_next_state = (bus.in_data == r_csum) ? S_RUN : S_ERR;
            end
            default: ;
        endcase
        if (reload) w_next_state = S_HDR_PC;
    end

    always_ff @(posedge CLK) begin
        if (resetl || reload) begin
            r_byte_idx     <= 3'd0;
            r_cnt_lo       <= 8'd0;
            r_count        <= '0;
            r_word_idx     <= '0;
            r_csum         <= 8'd0;
            r_word_buf     <= 32'd0;
            r_wr_pend      <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= 64'd0;
            bus.imem_wdata <= 32'd0;
            startpc        <= 64'd0;
            core_run       <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            words_loaded   <= '0;
        end else begin
            // completed words and final status surface one edge after the byte
            r_wr_pend   <= 1'b0;
            bus.imem_we <= r_wr_pend;
            if (r_wr_pend) begin
                bus.imem_addr  <= w_wr_addr;
                bus.imem_wdata <= r_word_buf;
                words_loaded   <= r_word_idx;
            end
            load_done <= (r_state == S_RUN);
            core_run  <= (r_state == S_RUN);
            load_err  <= (r_state == S_ERR);

            if (w_accept) begin
                r_byte_idx <= w_last_byte ? 3'd0 : r_byte_idx + 3'd1;
                case (r_state)
                    S_HDR_PC:  startpc <= {bus.in_data, startpc[63:8]};
                    S_HDR_CNT: begin
                        if (w_last_byte) r_count  <= CNT_W'(w_hdr_count);
                        else             r_cnt_lo <= bus.in_data;
                    end
                    S_DATA: begin
                        r_csum     <= r_csum ^ bus.in_data;
                        r_word_buf <= {bus.in_data, r_word_buf[31:8]};
                        if (w_last_byte) begin
                            r_wr_pend  <= 1'b1;
                            r_word_idx <= r_word_idx + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the single-cycle LEGv8 core.
- Receives a program image as a byte stream over a valid/ready handshake and writes 32-bit instruction words into instruction memory.
- Verifies an XOR checksum over the image, then releases the core with the loaded start PC.
- core_run connects to the core's run/reset-low input; startpc connects to the core's startpc.

Parameters:
- MAX_WORDS, 1024, maximum instruction words accepted per image.
- CNT_W, 16, width of the word-count field and counter.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- resetl  input  1  reset, synchronous, active-high.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- reload  input  1  single-cycle pulse; abort/restart a load from any state.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  64  byte address of the word being written.
- imem_wdata  output  32  instruction word being written.
- startpc  output  64  start PC from the image header.
- core_run  output  1  0 holds the core at startpc; 1 lets it run.
- load_done  output  1  image loaded and checksum matched.
- load_err  output  1  checksum mismatch or oversize count.
- words_loaded  output  CNT_W  words written in the current load.

Behaviour:
- Byte transfer: a byte is accepted on any posedge with in_valid && in_ready. in_ready is combinational from state: 1 in HDR_PC, HDR_CNT, DATA and CSUM; 0 in RUN and ERR.
- All multi-byte fields are little-endian (first byte = bits [7:0]).
- Reset (resetl=1 at posedge):
  - state=HDR_PC.
  - All outputs 0: imem_we, imem_addr, imem_wdata, startpc, core_run, load_done, load_err, words_loaded.
  - Internal byte index, word count and checksum accumulator are also 0.
- HDR_PC:
  - Accept 8 bytes into startpc.
  - After the 8th byte, go to HDR_CNT.
- HDR_CNT:
  - Accept 2 bytes into count N.
  - After the 2nd byte: if N>MAX_WORDS, go to ERR. If N==0, go to CSUM. Otherwise go to DATA.
- DATA:
  - Assemble 4 bytes per word; every accepted byte is XORed into the checksum accumulator.
  - When the 4th byte of word i is accepted at edge t, at edge t+1 the block registers: imem_we=1, imem_addr=startpc+4*i (64-bit wrap, no saturation), imem_wdata=the assembled word, and words_loaded=i+1.
  - imem_we is deasserted the following cycle unless another word completes. Back-to-back words give at most one strobe per 4 accepted bytes.
  - After word N-1, go to CSUM.
- CSUM:
  - Accept 1 byte.
  - If the byte equals the accumulator, go to RUN. Otherwise go to ERR.
  - The N==0 case expects 0x00.
- RUN:
  - load_done=1 and core_run=1, both registered at the edge after the checksum byte is accepted.
  - The final imem write therefore always precedes core_run by at least one cycle.
  - Remain in RUN until reload or reset.
- ERR:
  - load_err=1, core_run=0.
  - Remain in ERR until reload or reset.
- reload (sampled at posedge, any state):
  - Same effect as reset, except imem contents are untouched (no writes are issued).
  - Priority: resetl > reload > byte acceptance. A byte presented in the reload cycle is not accepted; in_ready is forced 0 that cycle.
- Mid-image stalls: in_valid may drop between any two bytes; no timeout; the partial word is held.
- startpc is stable from the end of HDR_PC until the next reload/reset. It is never updated while core_run=1.
- Gray areas resolved:
  - Bytes offered in RUN/ERR are not accepted and do not affect state.
  - words_loaded saturates at N.
  - load_done and load_err are never both 1.

Test Plan:
- Reset then image PC=0x0000_0000_0000_0100, N=2, words 0x8B1F03E1, 0xF8000001, correct CSUM=XOR of the 8 data bytes -> imem_we pulses with addr 0x100 data 0x8B1F03E1, then addr 0x104 data 0xF8000001; core_run=1 and load_done=1 one cycle after the CSUM byte; startpc=0x100.
- Same image with CSUM byte flipped (XOR 0x01) -> load_err=1, core_run stays 0, in_ready=0 afterwards, exactly 2 imem writes issued.
- Header N=MAX_WORDS+1 (0x0401 with default) -> ERR immediately after the 2nd count byte, zero imem writes.
- N=0 with CSUM 0x00 -> RUN with no imem_we; N=0 with CSUM 0x5A -> ERR.
- in_valid toggled randomly (50%) during DATA with PC=0xFFFF_FFFF_FFFF_FFFC, N=2 -> identical writes to the unstalled case; second write addr wraps to 0x0000_0000_0000_0000.
- reload asserted mid-DATA after 5 bytes, then a full valid image -> no write from the aborted partial word; words_loaded restarts at 0; new startpc used; core_run=1 only after the new CSUM. Separately, resetl asserted while in RUN -> all outputs 0 on the next edge.
